conv_accel_core: RTL and testbench
==================================

// Module: conv_accel_core
// PURPOSE
// 3x3 convolution accelerator. Loads a full signed kernel set once per run, then receives one
// KERNEL_SIZE^2 x INPUT_NB_CHANNELS input window per output pixel over three 16-bit buses. It
// emits one ACCUMULATION_WIDTH result per output channel, tagged with x/y/ch. It sits between
// the system I/O interface and the test program and reuses the same con_* buses for output.
// PARAMETERS
// IO_DATA_WIDTH 16 width of each con_* bus and of operands (signed)
// ACCUMULATION_WIDTH 32 accumulator/result width (signed, wraps mod 2^32)
// EXT_MEM_HEIGHT 1<<20 external memory depth (pass-through, unused inside)
// EXT_MEM_WIDTH 32 external memory width (pass-through, unused inside)
// FEATURE_MAP_WIDTH 64 output pixels per row (X)
// FEATURE_MAP_HEIGHT 64 output rows (Y)
// INPUT_NB_CHANNELS 4 input channels (CI)
// OUTPUT_NB_CHANNELS 32 output channels (CO)
// KERNEL_SIZE 3 kernel side; one bus beat carries one kernel row of 3 values
// PORTS
// clk in 1 clock, all logic on rising edge
// arst_n_in in 1 reset, synchronous, active-HIGH despite legacy name
// con_1/con_2/con_3 inout 16 each: data in when driving_cons=0, result out when 1 (else 'z)
// con_valid in 1 producer has a beat on con_1..3
// con_ready out 1 core accepts a beat this cycle
// output_valid out 1 result on con_1 (acc[15:0]) / con_2 (acc[31:16]), con_3=0
// output_x out $clog2(FEATURE_MAP_WIDTH) x of result
// output_y out $clog2(FEATURE_MAP_HEIGHT) y of result
// output_ch out $clog2(OUTPUT_NB_CHANNELS) output channel of result
// start in 1 begin a run (sampled in IDLE only)
// running out 1 high from the cycle after start until the final result cycle inclusive
// driving_cons out 1 core drives con_1..3
// last_load_K out 1 high in the cycle the final kernel beat is accepted
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset, any state: FSM->IDLE, counters 0. con_ready, output_valid, running, driving_cons,
//   last_load_K are 0; output_x/y/ch are 0. Kernel/window storage is not reset.
// - Beat transfer = con_valid & con_ready. con_ready is high only in LOAD_K and LOAD_WIN.
// - A beat's con_1/con_2/con_3 carry kx=0/1/2.
// - IDLE: start=1 -> LOAD_K. start is ignored in every other state.
// - LOAD_K: 384 beats, order co(outer), ky, ci(inner), i.e. CO*KS*CI beats.
//   Store K[co][ky][ci][kx]. On the final beat, last_load_K=1, then go to LOAD_WIN.
// - LOAD_WIN: 12 beats, order ky(outer), ci(inner). Fill W[ky][ci][kx] for the current
//   pixel. The producer supplies zero padding at borders. After the 12th beat -> COMPUTE, co=0.
// - COMPUTE: 12 cycles per co, 3 signed 16x16->32 multipliers/cycle. acc cleared on the first
//   cycle, then acc += sum of 3 products (mod 2^32). Use the team adder/multiplier modules
//   for the datapath. -> OUTPUT.
// - OUTPUT: 1 cycle with output_valid=1, driving_cons=1, con_1=acc[15:0], con_2=acc[31:16],
//   con_3=0 and output_x/y/ch = current pixel and co.
//   No backpressure: con_valid is ignored in this state.
//   Next state: co<31 -> COMPUTE with co+1. Else next pixel (x inner, y outer) -> LOAD_WIN.
//   Else (x=63,y=63) -> IDLE with running=0 on the following cycle.
// - Latency: first output_valid is 13 cycles after the 12th window beat. 13 cycles per channel.
// - con_valid low stalls the load counters. Reset mid-run aborts; the next start reloads kernels.
// - driving_cons is 0 in every non-OUTPUT state; con_* are then high-Z from the core.
// TESTING
// - Reset: assert arst_n_in=1 for 2 cycles mid-COMPUTE -> all outputs 0, con_ready=0, IDLE.
// - Kernel load: start, 384 beats with con_valid=1 -> last_load_K=1 only on beat 384;
//   con_ready stays high.
// - Identity: K[0][1][0][1]=1, all else 0; window center ci0=7 -> ch0 result 7, ch1..31 result 0.
// - All ones: K=1, W=2 -> every channel 72 (con_1=0x0048, con_2=0); pixel (0,0), ch 0..31 in order.
// - Signed: K=-1, W=3 -> -108: con_1=0xFF94, con_2=0xFFFF.
// - Stalls: random con_valid gaps during LOAD_WIN -> identical results; x advances 0->1 after ch31.

Source files
------------

// File: rtl/conv_accel_core.sv
// conv_accel_core: 3x3 convolution accelerator core.
// Loads a signed kernel set once per run, then for each output pixel takes one
// KERNEL_SIZE x INPUT_NB_CHANNELS window and emits one accumulated result per
// output channel on the shared con_* buses.
// Ports:
//   clk, arst_n_in     clock; synchronous active-high reset (legacy name)
//   con_1/2/3          shared buses: kernel/window lanes kx=0/1/2 in, result out
//   con_valid/ready    beat handshake (ready only while loading)
//   output_valid       result present: con_1=acc[15:0], con_2=acc[31:16], con_3=0
//   output_x/y/ch      pixel coordinates and output channel of the result
//   start, running     run control and run-in-progress flag
//   driving_cons       core owns the con_* buses
//   last_load_K        final kernel beat is being accepted
module conv_accel_core #(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned ACCUMULATION_WIDTH = 32,
  parameter int unsigned EXT_MEM_HEIGHT     = 1 << 20,
  parameter int unsigned EXT_MEM_WIDTH      = 32,
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned INPUT_NB_CHANNELS  = 4,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned KERNEL_SIZE        = 3
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  inout  wire  [IO_DATA_WIDTH-1:0]              con_1,
  inout  wire  [IO_DATA_WIDTH-1:0]              con_2,
  inout  wire  [IO_DATA_WIDTH-1:0]              con_3,
  input  logic                                  con_valid,
  output logic                                  con_ready,
  output logic                                  output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  input  logic                                  start,
  output logic                                  running,
  output logic                                  driving_cons,
  output logic                                  last_load_K
);

  localparam int unsigned IOW       = IO_DATA_WIDTH;
  localparam int unsigned ACCW      = ACCUMULATION_WIDTH;
  localparam int unsigned PW        = 2 * IO_DATA_WIDTH;
  localparam int unsigned LANES     = 3;
  localparam int unsigned LANEW     = LANES * IO_DATA_WIDTH;
  localparam int unsigned XW        = $clog2(FEATURE_MAP_WIDTH);
  localparam int unsigned YW        = $clog2(FEATURE_MAP_HEIGHT);
  localparam int unsigned CHW       = $clog2(OUTPUT_NB_CHANNELS);
  localparam int unsigned WIN_BEATS = KERNEL_SIZE * INPUT_NB_CHANNELS;
  localparam int unsigned K_BEATS   = OUTPUT_NB_CHANNELS * WIN_BEATS;
  localparam int unsigned KW        = $clog2(K_BEATS);
  localparam int unsigned WW        = $clog2(WIN_BEATS);

  // External memory geometry is carried for the system wrapper only.
  if (EXT_MEM_HEIGHT == 0 || EXT_MEM_WIDTH == 0) begin : g_ext_mem_unused
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_WIN,
    S_COMPUTE,
    S_OUTPUT
  } state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     kcnt_q, kcnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [WW-1:0]     step_q, step_d;
  logic [CHW-1:0]    co_q, co_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              con_ready_q, con_ready_d;
  logic              output_valid_q, output_valid_d;
  logic              running_q, running_d;
  logic              driving_cons_q, driving_cons_d;
  logic              last_load_k_q, last_load_k_d;
  logic [XW-1:0]     out_x_q, out_x_d;
  logic [YW-1:0]     out_y_q, out_y_d;
  logic [CHW-1:0]    out_ch_q, out_ch_d;

  // Kernel words are indexed co*WIN_BEATS + beat; window words by beat.
  logic [LANEW-1:0]  k_mem [K_BEATS];
  logic [LANEW-1:0]  w_mem [WIN_BEATS];

  logic              beat;
  logic              k_we, w_we;
  logic [LANEW-1:0]  in_word;
  logic [KW-1:0]     k_idx;
  logic [LANEW-1:0]  k_word, w_word;
  logic signed [IOW-1:0]  op_w, op_k;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] lane_sum;

  assign in_word = {con_3, con_2, con_1};
  assign beat    = con_valid & con_ready_q;
  assign k_we    = beat && (state_q == S_LOAD_K);
  assign w_we    = beat && (state_q == S_LOAD_WIN);

  // One kernel row per cycle: three signed products summed into the accumulator.
  always_comb begin
    k_idx    = KW'(co_q) * KW'(WIN_BEATS) + KW'(step_q);
    k_word   = k_mem[k_idx];
    w_word   = w_mem[step_q];
    lane_sum = '0;
    op_w     = '0;
    op_k     = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      op_w     = w_word[l*IOW +: IOW];
      op_k     = k_word[l*IOW +: IOW];
      prod     = PW'(op_w) * PW'(op_k);
      lane_sum = lane_sum + ACCW'(prod);
    end
  end

  // Next-state, counters and registered output values.
  always_comb begin
    state_d        = state_q;
    kcnt_d         = kcnt_q;
    wcnt_d         = wcnt_q;
    step_d         = step_q;
    co_d           = co_q;
    px_d           = px_q;
    py_d           = py_q;
    acc_d          = acc_q;
    out_x_d        = out_x_q;
    out_y_d        = out_y_q;
    out_ch_d       = out_ch_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_K;
          kcnt_d  = '0;
          px_d    = '0;
          py_d    = '0;
        end
      end
      S_LOAD_K: begin
        if (beat) begin
          if (kcnt_q == KW'(K_BEATS - 1)) begin
            state_d = S_LOAD_WIN;
            wcnt_d  = '0;
          end else begin
            kcnt_d = kcnt_q + KW'(1);
          end
        end
      end
      S_LOAD_WIN: begin
        if (beat) begin
          if (wcnt_q == WW'(WIN_BEATS - 1)) begin
            state_d = S_COMPUTE;
            co_d    = '0;
            step_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      S_COMPUTE: begin
        // First step overwrites the previous channel's result.
        acc_d = ((step_q == '0) ? '0 : acc_q) + lane_sum;
        if (step_q == WW'(WIN_BEATS - 1)) begin
          state_d = S_OUTPUT;
        end else begin
          step_d = step_q + WW'(1);
        end
      end
      S_OUTPUT: begin
        if (co_q != CHW'(OUTPUT_NB_CHANNELS - 1)) begin
          state_d = S_COMPUTE;
          co_d    = co_q + CHW'(1);
          step_d  = '0;
        end else if (px_q != XW'(FEATURE_MAP_WIDTH - 1)) begin
          state_d = S_LOAD_WIN;
          px_d    = px_q + XW'(1);
          wcnt_d  = '0;
        end else if (py_q != YW'(FEATURE_MAP_HEIGHT - 1)) begin
          state_d = S_LOAD_WIN;
          px_d    = '0;
          py_d    = py_q + YW'(1);
          wcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    con_ready_d    = (state_d == S_LOAD_K) || (state_d == S_LOAD_WIN);
    output_valid_d = (state_d == S_OUTPUT);
    driving_cons_d = (state_d == S_OUTPUT);
    running_d      = (state_d != S_IDLE);
    last_load_k_d  = (state_d == S_LOAD_K) && (kcnt_d == KW'(K_BEATS - 1));
    if (state_d == S_OUTPUT) begin
      out_x_d  = px_d;
      out_y_d  = py_d;
      out_ch_d = co_d;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (arst_n_in) begin
      state_q        <= S_IDLE;
      kcnt_q         <= '0;
      wcnt_q         <= '0;
      step_q         <= '0;
      co_q           <= '0;
      px_q           <= '0;
      py_q           <= '0;
      acc_q          <= '0;
      con_ready_q    <= 1'b0;
      output_valid_q <= 1'b0;
      running_q      <= 1'b0;
      driving_cons_q <= 1'b0;
      last_load_k_q  <= 1'b0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_ch_q       <= '0;
    end else begin
      state_q        <= state_d;
      kcnt_q         <= kcnt_d;
      wcnt_q         <= wcnt_d;
      step_q         <= step_d;
      co_q           <= co_d;
      px_q           <= px_d;
      py_q           <= py_d;
      acc_q          <= acc_d;
      con_ready_q    <= con_ready_d;
      output_valid_q <= output_valid_d;
      running_q      <= running_d;
      driving_cons_q <= driving_cons_d;
      last_load_k_q  <= last_load_k_d;
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
      out_ch_q       <= out_ch_d;
    end
  end

  // Kernel and window storage (not reset).
  always_ff @(posedge clk) begin
    if (k_we) k_mem[kcnt_q] <= in_word;
    if (w_we) w_mem[wcnt_q] <= in_word;
  end

  assign con_1 = driving_cons_q ? acc_q[IOW-1:0]     : 'z;
  assign con_2 = driving_cons_q ? acc_q[2*IOW-1:IOW] : 'z;
  assign con_3 = driving_cons_q ? '0                 : 'z;

  assign con_ready    = con_ready_q;
  assign output_valid = output_valid_q;
  assign running      = running_q;
  assign driving_cons = driving_cons_q;
  assign last_load_K  = last_load_k_q;
  assign output_x     = out_x_q;
  assign output_y     = out_y_q;
  assign output_ch    = out_ch_q;

endmodule

// File: tb/tb_conv_accel_core.sv
// Directed bench for conv_accel_core: reset, kernel load, identity,
// all-ones, signed and stalled-window results.
module tb_conv_accel_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        con_valid;
  logic        start;
  logic [15:0] d1, d2, d3;
  wire  [15:0] con_1, con_2, con_3;
  logic        con_ready, output_valid, running, driving_cons, last_load_K;
  logic [5:0]  output_x, output_y;
  logic [4:0]  output_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bench drives the shared buses only while the core is not driving them.
  assign con_1 = driving_cons ? 'z : d1;
  assign con_2 = driving_cons ? 'z : d2;
  assign con_3 = driving_cons ? 'z : d3;

  conv_accel_core dut (
    .clk          (clk),
    .arst_n_in    (rst),
    .con_1        (con_1),
    .con_2        (con_2),
    .con_3        (con_3),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .output_valid (output_valid),
    .output_x     (output_x),
    .output_y     (output_y),
    .output_ch    (output_ch),
    .start        (start),
    .running      (running),
    .driving_cons (driving_cons),
    .last_load_K  (last_load_K)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, 32'({con_ready, output_valid, running, driving_cons, last_load_K,
                  output_x, output_y, output_ch}), 32'd0);
  endtask

  // mode 0: K[0][1][0][1]=1 else 0; mode 1: all 1; mode 2: all -1.
  task automatic load_kernel(input int mode);
    int ready_bad = 0;
    int last_hits = 0;
    int last_pos  = -1;
    for (int i = 0; i < 384; i++) begin
      case (mode)
        0:       begin d1 = 16'h0; d2 = (i == 4) ? 16'h1 : 16'h0; d3 = 16'h0; end
        1:       begin d1 = 16'h1; d2 = 16'h1; d3 = 16'h1; end
        default: begin d1 = 16'hFFFF; d2 = 16'hFFFF; d3 = 16'hFFFF; end
      endcase
      con_valid = 1'b1;
      if (!con_ready) ready_bad++;
      if (last_load_K) begin
        last_hits++;
        last_pos = i;
      end
      tick();
    end
    con_valid = 1'b0;
    chk("kload_ready_high", 32'(ready_bad), 32'd0);
    chk("kload_last_count", 32'(last_hits), 32'd1);
    chk("kload_last_beat", 32'(last_pos), 32'd383);
  endtask

  // Presents one beat and holds it until the core accepts it.
  task automatic send_beat(input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    int n = 0;
    d1 = v1; d2 = v2; d3 = v3;
    con_valid = 1'b1;
    while (!con_ready && n < 50) begin
      tick();
      n++;
    end
    chk("beat_ready", 32'(con_ready), 32'd1);
    tick();
  endtask

  // mode 0: identity window (center ci0 = 7, other taps nonzero); 1: all 2; 2: all 3.
  task automatic load_window(input int mode, input bit stall);
    logic [15:0] v1, v2, v3;
    for (int b = 0; b < 12; b++) begin
      if (stall) begin
        con_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      case (mode)
        0: begin
          v1 = 16'(b * 3 + 1);
          v2 = (b == 4) ? 16'd7 : 16'(b * 3 + 2);
          v3 = 16'(b * 3 + 3);
        end
        1:       begin v1 = 16'd2; v2 = 16'd2; v3 = 16'd2; end
        default: begin v1 = 16'd3; v2 = 16'd3; v3 = 16'd3; end
      endcase
      send_beat(v1, v2, v3);
    end
    con_valid = 1'b0;
  endtask

  // Waits for one result, checks it, then steps past the output cycle.
  task automatic wait_out(input logic [31:0] exp_acc, input int x, input int y, input int ch,
                          output int waited);
    int n = 0;
    while (!output_valid && n < 40) begin
      tick();
      n++;
    end
    waited = n;
    chk($sformatf("out_valid x%0d ch%0d", x, ch), 32'(output_valid), 32'd1);
    chk($sformatf("con_1 x%0d ch%0d", x, ch), 32'(con_1), 32'(exp_acc[15:0]));
    chk($sformatf("con_2 x%0d ch%0d", x, ch), 32'(con_2), 32'(exp_acc[31:16]));
    chk($sformatf("con_3 x%0d ch%0d", x, ch), 32'(con_3), 32'd0);
    chk($sformatf("xyc x%0d ch%0d", x, ch), 32'({output_x, output_y, output_ch}),
        32'({6'(x), 6'(y), 5'(ch)}));
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    rst = 1'b1; con_valid = 1'b0; start = 1'b0;
    d1 = '0; d2 = '0; d3 = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_idle("reset_idle");

    // Identity kernel, first pixel.
    do_start();
    chk("running_after_start", 32'(running), 32'd1);
    chk("kload_ready_first", 32'(con_ready), 32'd1);
    load_kernel(0);
    chk("win_ready", 32'(con_ready), 32'd1);
    chk("last_load_cleared", 32'(last_load_K), 32'd0);
    load_window(0, 1'b0);
    n = 1;
    while (!output_valid && n < 40) begin
      tick();
      n++;
    end
    chk("first_latency", 32'(n), 32'd13);
    wait_out(32'd7, 0, 0, 0, w);
    chk("valid_pulse", 32'({output_valid, driving_cons}), 32'd0);
    wait_out(32'd0, 0, 0, 1, w);
    chk("channel_gap", 32'(w + 1), 32'd13);
    for (int ch = 2; ch < 32; ch++) wait_out(32'd0, 0, 0, ch, w);
    chk("next_pixel_ready", 32'({running, con_ready}), 32'd3);

    // Reset in the middle of COMPUTE.
    load_window(0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_idle("midrun_reset_held");
    rst = 1'b0;
    repeat (3) tick();
    check_idle("midrun_reset_idle");

    // All-ones kernel, window of 2s; second pixel with stalled window beats.
    do_start();
    load_kernel(1);
    load_window(1, 1'b0);
    for (int ch = 0; ch < 32; ch++) wait_out(32'd72, 0, 0, ch, w);
    load_window(1, 1'b1);
    for (int ch = 0; ch < 32; ch++) wait_out(32'd72, 1, 0, ch, w);

    // Signed: kernel -1, window 3 -> -108.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    do_start();
    load_kernel(2);
    load_window(2, 1'b1);
    wait_out(32'hFFFF_FF94, 0, 0, 0, w);
    wait_out(32'hFFFF_FF94, 0, 0, 1, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
